// File: rtl/des_seq_pkg.sv
// des_seq_pkg: shared types, key schedule and rotate helpers
// for the DES round sequencer.
package des_seq_pkg;

  localparam int DES_ROUNDS = 16;
  localparam int RND_W = $clog2(DES_ROUNDS) + 1;
  localparam int IDX_W = $clog2(DES_ROUNDS);

  typedef logic [27:0] half_t;
  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROT,
    S_START,
    S_WAIT,
    S_OUT
  } state_e;

  // entry k-1 holds the left shift of round k
  localparam logic [1:0] SHIFT_SCHEDULE [DES_ROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2,
    2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2,
    2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [1:0] shift_of(
    input logic [RND_W-1:0] rnd
  );
    logic [IDX_W-1:0] idx;
    idx = IDX_W'(rnd - 1'b1);
    return SHIFT_SCHEDULE[idx];
  endfunction

  function automatic half_t rot28_l(
    input half_t x,
    input logic [1:0] n
  );
    half_t y;
    unique case (n)
      2'd1:    y = {x[26:0], x[27]};
      2'd2:    y = {x[25:0], x[27:26]};
      2'd3:    y = {x[24:0], x[27:25]};
      default: y = x;
    endcase
    return y;
  endfunction

  function automatic half_t rot28_r(
    input half_t x,
    input logic [1:0] n
  );
    half_t y;
    unique case (n)
      2'd1:    y = {x[0], x[27:1]};
      2'd2:    y = {x[1:0], x[27:2]};
      2'd3:    y = {x[2:0], x[27:3]};
      default: y = x;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/des_keyhalf_rotator.sv
// des_keyhalf_rotator: combinational rotate of both key halves.
// c_i/d_i in, amt_i (0..3), dir_i (0 left, 1 right), c_o/d_o out.
module des_keyhalf_rotator
  import des_seq_pkg::*;
(
  input  logic [27:0] c_i,
  input  logic [27:0] d_i,
  input  logic [1:0]  amt_i,
  input  logic        dir_i,
  output logic [27:0] c_o,
  output logic [27:0] d_o
);

  always_comb begin
    if (dir_i) begin
      c_o = rot28_r(c_i, amt_i);
      d_o = rot28_r(d_i, amt_i);
    end else begin
      c_o = rot28_l(c_i, amt_i);
      d_o = rot28_l(d_i, amt_i);
    end
  end

endmodule

// File: rtl/des_round_sequencer.sv
// des_round_sequencer: runs one round core over all DES rounds.
// in_*: block source, out_*: result sink, core_*: ap_ctrl_hs core.
module des_round_sequencer
  import des_seq_pkg::*;
#(
  parameter int NUM_ROUNDS     = DES_ROUNDS,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mode,
  input  logic [27:0] in_c,
  input  logic [27:0] in_d,
  input  logic [31:0] in_l,
  input  logic [31:0] in_r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        err,
  output logic        core_start,
  input  logic        core_ready,
  input  logic        core_done,
  input  logic        core_idle,
  output logic [27:0] core_c,
  output logic [27:0] core_d,
  output logic [31:0] core_l,
  output logic [31:0] core_r,
  input  logic [63:0] core_return
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RND_W-1:0] RND_LAST =
    RND_W'(NUM_ROUNDS);
  localparam logic [RND_W-1:0] RND_MIRROR =
    RND_W'(NUM_ROUNDS + 2);

  state_e           state_q, state_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  half_t            c_q, c_d;
  half_t            d_q, d_d;
  word_t            l_q, l_d;
  word_t            r_q, r_d;
  logic             mode_q, mode_d;
  logic             err_q, err_d;

  logic             rnd_done;
  logic [1:0]       rot_amt;
  logic             rot_dir;
  half_t            rot_c, rot_d;

  // decrypt walks the schedule backwards, one round behind
  always_comb begin
    rot_dir = mode_q;
    rot_amt = shift_of(rnd_q);
    if (mode_q) begin
      if (rnd_q == RND_W'(1)) begin
        rot_amt = 2'd0;
      end else begin
        rot_amt = shift_of(RND_MIRROR - rnd_q);
      end
    end
  end

  des_keyhalf_rotator u_rot (
    .c_i   (c_q),
    .d_i   (d_q),
    .amt_i (rot_amt),
    .dir_i (rot_dir),
    .c_o   (rot_c),
    .d_o   (rot_d)
  );

  // after a timeout the core may still be busy; wait for idle
  assign in_ready = ap_rst_n
                  && (state_q == S_IDLE)
                  && (!err_q || core_idle);

  assign core_start = (state_q == S_START);
  assign out_valid  = (state_q == S_OUT);
  assign out_data   = out_valid ? {r_q, l_q} : '0;
  assign err        = err_q;
  assign core_c     = c_q;
  assign core_d     = d_q;
  assign core_l     = l_q;
  assign core_r     = r_q;

  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    tmo_d    = tmo_q;
    c_d      = c_q;
    d_d      = d_q;
    l_d      = l_q;
    r_d      = r_q;
    mode_d   = mode_q;
    err_d    = err_q;
    rnd_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          c_d     = in_c;
          d_d     = in_d;
          l_d     = in_l;
          r_d     = in_r;
          mode_d  = in_mode;
          rnd_d   = RND_W'(1);
          err_d   = 1'b0;
          state_d = S_ROT;
        end
      end
      S_ROT: begin
        c_d     = rot_c;
        d_d     = rot_d;
        tmo_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        tmo_d = tmo_q + 1'b1;
        if (core_ready && core_done) begin
          rnd_done = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (core_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (core_done) begin
          rnd_done = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // a finished round beats a same-cycle timeout
    if (rnd_done) begin
      l_d = core_return[63:32];
      r_d = core_return[31:0];
      if (rnd_q == RND_LAST) begin
        state_d = S_OUT;
      end else begin
        rnd_d   = rnd_q + 1'b1;
        state_d = S_ROT;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      rnd_q   <= '0;
      tmo_q   <= '0;
      c_q     <= '0;
      d_q     <= '0;
      l_q     <= '0;
      r_q     <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      tmo_q   <= tmo_d;
      c_q     <= c_d;
      d_q     <= d_d;
      l_q     <= l_d;
      r_q     <= r_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

endmodule
